gpr_file_param: RTL and testbench
=================================

Name: gpr_file_param

Overview:
- Parametrised general-purpose register file for the multi-cycle core.
- Generalised in data width, depth and number of read ports, with a selectable write-destination mux (Rt / Rd / link register).
- Adds a sequenced post-reset clear, optional write-to-read bypass, and a per-register pending-write scoreboard so the control FSM can detect RAW hazards.
- Sits between decode (addresses) and the ALU operand muxes (read data).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of independent read ports.
- LINK_REG, 31, destination index forced when dst_sel selects link.
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/reservations.
- BYPASS, 1, 1 = a read of the address being written this cycle returns busW.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- regWr  in  1  write enable.
- Rt  in  ADDR_W  destination candidate 0.
- Rd  in  ADDR_W  destination candidate 1.
- dst_sel  in  2  destination select: 0=Rt, 1=Rd, 2=LINK_REG, 3=Rt.
- busW  in  DATA_W  write data.
- rsv_en  in  1  mark a register as pending (instruction issued, result not yet written).
- rsv_addr  in  ADDR_W  register to mark pending.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies slice k.
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_pending  out  NUM_RD  pending bit of each read address.
- Rw  out  ADDR_W  resolved write destination (combinational from dst_sel/Rt/Rd).
- ready  out  1  high once the clear sequence is complete.

Behaviour:
- States are CLEAR and READY.
- **CLEAR**
  - While reset=1: state=CLEAR, clear index=0, all pending bits=0, ready=0.
  - After reset deasserts, each rising edge zeroes entry[index] and increments index.
  - The edge that zeroes entry DEPTH-1 moves the block to READY.
  - ready=1 exactly DEPTH rising edges after the first edge sampling reset=0.
  - During CLEAR: regWr and rsv_en are ignored, rd_data=0, rd_pending=0.
- **Reset mid-operation** (any state): the sequence restarts from index 0 and pending bits clear on that edge. Partially cleared contents are don't-care but must never be visible, because rd_data=0 until ready.
- **Write (READY)**
  - If regWr=1, entry[Rw] <= busW and pending[Rw] <= 0 on the rising edge.
  - Write-to-read latency is 1 edge; with BYPASS=1 the latency is 0 (same-cycle forward).
- **Reads:** combinational. rd_data[k] = entry[rd_addr[k]], or busW when BYPASS=1, regWr=1 and rd_addr[k]==Rw.
- **ZERO_REG=1**
  - Reads of address 0 return 0, including under bypass.
  - Writes and reservations to address 0 are dropped; pending[0] is always 0.
- **Reservation:** if rsv_en=1 in READY, pending[rsv_addr] <= 1.
- **Simultaneous write and reserve to the same address:** the reservation wins and pending stays 1, supporting back-to-back producers.
- **Different addresses:** write and reserve to different addresses act independently on the same edge.
- **rd_pending[k]:** equals pending[rd_addr[k]], except it is 0 when that address is being written this cycle with BYPASS=1 (data already forwarded).
- **Rw** is valid in all states; dst_sel=3 behaves as 0.
- There is no storage beyond DEPTH entries and no wrap-around of addresses, since the full address range is used.

Test Plan:
- Reset 1 cycle, then release → ready=0 for edges 1..31 and 1 after edge 32 (DEPTH=32); all ports read 0 throughout.
- Write sequence:
  - In READY, regWr=1, dst_sel=1, Rd=7, busW=0xDEADBEEF; rd_addr port0=7 in the same cycle → port0=0xDEADBEEF (bypass).
  - Next cycle with regWr=0, port1=7 → 0xDEADBEEF.
- dst_sel=2, regWr=1, busW=0x00400010 → Rw=31, entry31=0x00400010; write Rd=0 with busW=0xFFFFFFFF → read of 0 returns 0.
- Pending sequence:
  - rsv_en, rsv_addr=9 → rd_pending=1 for addr 9 from the next cycle.
  - Write to 9 → pending=0 in the same cycle (bypass) and afterwards.
  - Write and reserve to 9 on the same edge → pending remains 1.
- Mid-run reset:
  - Write entry 5=0x1234, reserve 12, assert reset 1 cycle → pending cleared, ready=0 for 32 edges.
  - Afterwards entry 5 reads 0 and a regWr during CLEAR has no effect.
- NUM_RD=3, DATA_W=16, BYPASS=0 instance:
  - Write entry 3=0xA5A5 → same-cycle read of 3 returns the old value; next cycle all three ports reading 3 return 0xA5A5.

Source files
------------

// File: rtl/gpr_file_param_if.sv
// Register-file access bundle between decode/control and the register file.
// Carries the write request (regWr, Rt/Rd/dst_sel, busW), the reservation
// request (rsv_en, rsv_addr), the packed read ports (rd_addr in;
// rd_data, rd_pending out), the resolved destination Rw and the ready flag.
// master: decode/control side; slave: the register file.
interface gpr_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       regWr;
    logic [ADDR_W-1:0]          Rt;
    logic [ADDR_W-1:0]          Rd;
    logic [1:0]                 dst_sel;
    logic [DATA_W-1:0]          busW;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_addr;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_pending;
    logic [ADDR_W-1:0]          Rw;
    logic                       ready;

    modport master (
        output regWr, Rt, Rd, dst_sel, busW, rsv_en, rsv_addr, rd_addr,
        input  rd_data, rd_pending, Rw, ready
    );

    modport slave (
        input  regWr, Rt, Rd, dst_sel, busW, rsv_en, rsv_addr, rd_addr,
        output rd_data, rd_pending, Rw, ready
    );
endinterface

// File: rtl/gpr_file_param.sv
// Parametrised general-purpose register file with post-reset clear sequence,
// optional write-to-read bypass and per-register pending-write scoreboard.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; restarts the clear sequence
//   bus    gpr_file_param_if.slave: write/reserve requests in, read data,
//          pending bits, resolved destination Rw and ready out
//
// state | meaning
// CLEAR | zeroing entry[clr_idx] each edge; writes/reservations ignored, reads 0
// READY | normal operation
module gpr_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = 31,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               reset,
    gpr_file_param_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]   pending_q;
    logic [ADDR_W-1:0]  rw;
    logic               is_ready;
    logic               wr_ok;
    logic               rsv_ok;
    logic [ADDR_W-1:0]  ra;
    logic               fwd;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]  rd_pend_c;

    always_comb begin
        case (bus.dst_sel)
            2'd1:    rw = bus.Rd;
            2'd2:    rw = ADDR_W'(LINK_REG);
            default: rw = bus.Rt;
        endcase
    end

    assign is_ready = (state_q == READY);
    assign wr_ok  = bus.regWr  && is_ready && !((ZERO_REG != 0) && (rw == '0));
    assign rsv_ok = bus.rsv_en && is_ready && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == '1)
                    state_d = READY;
            end
            default: ;
        endcase
    end

    // Storage has no reset; the clear sequence zeroes it and reads are gated
    // by ready so partially cleared contents never leak out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR)
                mem[clr_idx_q] <= '0;
            else if (wr_ok)
                mem[rw] <= bus.busW;
        end
    end

    // Reservation is applied after the write clear so it wins on the same
    // address, letting back-to-back producers keep the register pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            if (wr_ok)
                pending_q[rw] <= 1'b0;
            if (rsv_ok)
                pending_q[bus.rsv_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_pend_c = '0;
        ra        = '0;
        fwd       = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra  = bus.rd_addr[k*ADDR_W +: ADDR_W];
            fwd = (BYPASS != 0) && wr_ok && (ra == rw);
            if (is_ready) begin
                if (fwd)
                    rd_data_c[k*DATA_W +: DATA_W] = bus.busW;
                else if (!((ZERO_REG != 0) && (ra == '0)))
                    rd_data_c[k*DATA_W +: DATA_W] = mem[ra];
                rd_pend_c[k] = pending_q[ra] && !fwd;
            end
        end
    end

    assign bus.rd_data    = rd_data_c;
    assign bus.rd_pending = rd_pend_c;
    assign bus.Rw         = rw;
    assign bus.ready      = is_ready;
endmodule

// File: tb/tb_gpr_file_param.sv
// Directed testbench for gpr_file_param: default instance (32b, 2 read ports,
// bypass) and a 16b, 3-port, no-bypass instance sharing clock and reset.
module tb_gpr_file_param;
    logic clk;
    logic reset;
    int   n_tot;
    int   n_bad;

    gpr_file_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b0 ();
    gpr_file_param_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3)) b1 ();

    gpr_file_param u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    gpr_file_param #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3), .BYPASS(0)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_tot = 0;
        n_bad = 0;
        reset = 1'b1;
        b0.regWr = 0; b0.Rt = '0; b0.Rd = '0; b0.dst_sel = '0; b0.busW = '0;
        b0.rsv_en = 0; b0.rsv_addr = '0; b0.rd_addr = '0;
        b1.regWr = 0; b1.Rt = '0; b1.Rd = '0; b1.dst_sel = '0; b1.busW = '0;
        b1.rsv_en = 0; b1.rsv_addr = '0; b1.rd_addr = '0;

        step();
        reset = 1'b0;
        b0.rd_addr = {5'd7, 5'd3};
        settle();
        chk("rst_ready", 64'(b0.ready), 64'd0);
        chk("rst_pend", 64'(b0.rd_pending), 64'd0);

        // first clear sequence: ready rises exactly on edge 32
        for (int i = 1; i <= 32; i++) begin
            step();
            chk($sformatf("clr_ready_%0d", i), 64'(b0.ready), 64'(i == 32));
            if (i < 32)
                chk($sformatf("clr_data_%0d", i), 64'(b0.rd_data), 64'd0);
        end
        chk("u1_ready", 64'(b1.ready), 64'd1);

        // write with same-cycle bypass, then registered read on port 1
        b0.regWr = 1; b0.dst_sel = 2'd1; b0.Rd = 5'd7; b0.busW = 32'hDEADBEEF;
        b0.rd_addr = {5'd0, 5'd7};
        settle();
        chk("wr_rw", 64'(b0.Rw), 64'd7);
        chk("wr_bypass", 64'(b0.rd_data), {32'h0, 32'h0, 32'hDEADBEEF});
        step();
        b0.regWr = 0; b0.rd_addr = {5'd7, 5'd0};
        settle();
        chk("wr_read_p1", 64'(b0.rd_data), {32'h0, 32'hDEADBEEF, 32'h0});

        // link destination and dst_sel=3 alias
        b0.regWr = 1; b0.dst_sel = 2'd2; b0.Rt = 5'd3; b0.Rd = 5'd4; b0.busW = 32'h00400010;
        settle();
        chk("link_rw", 64'(b0.Rw), 64'd31);
        step();
        b0.regWr = 0; b0.dst_sel = 2'd3; b0.rd_addr = {5'd0, 5'd31};
        settle();
        chk("sel3_rw", 64'(b0.Rw), 64'd3);
        chk("link_read", 64'(b0.rd_data), {32'h0, 32'h0, 32'h00400010});

        // zero register: write dropped, bypass suppressed
        b0.regWr = 1; b0.dst_sel = 2'd1; b0.Rd = 5'd0; b0.busW = 32'hFFFFFFFF;
        b0.rd_addr = {5'd0, 5'd0};
        settle();
        chk("zero_bypass", 64'(b0.rd_data), 64'd0);
        step();
        b0.regWr = 0;
        settle();
        chk("zero_read", 64'(b0.rd_data), 64'd0);

        // reservation visible from next cycle
        b0.rsv_en = 1; b0.rsv_addr = 5'd9; b0.rd_addr = {5'd8, 5'd9};
        settle();
        chk("rsv_same", 64'(b0.rd_pending), 64'd0);
        step();
        b0.rsv_en = 0;
        settle();
        chk("rsv_next", 64'(b0.rd_pending), 64'b01);

        // write clears pending, masked in the same cycle under bypass
        b0.regWr = 1; b0.Rd = 5'd9; b0.busW = 32'h99;
        settle();
        chk("wr9_pend_same", 64'(b0.rd_pending), 64'd0);
        chk("wr9_data_same", 64'(b0.rd_data), {32'h0, 32'h0, 32'h99});
        step();
        b0.regWr = 0;
        settle();
        chk("wr9_pend_after", 64'(b0.rd_pending), 64'd0);

        // same-edge write and reserve: reservation wins
        b0.regWr = 1; b0.busW = 32'hAA; b0.rsv_en = 1; b0.rsv_addr = 5'd9;
        step();
        b0.regWr = 0; b0.rsv_en = 0;
        settle();
        chk("wr_rsv_pend", 64'(b0.rd_pending), 64'b01);
        chk("wr_rsv_data", 64'(b0.rd_data), {32'h0, 32'h0, 32'hAA});

        // reservation of register 0 dropped
        b0.rsv_en = 1; b0.rsv_addr = 5'd0;
        step();
        b0.rsv_en = 0; b0.rd_addr = {5'd9, 5'd0};
        settle();
        chk("rsv0_pend", 64'(b0.rd_pending), 64'b10);

        // write 9 and reserve 10 on the same edge act independently
        b0.regWr = 1; b0.Rd = 5'd9; b0.busW = 32'hBB; b0.rsv_en = 1; b0.rsv_addr = 5'd10;
        step();
        b0.regWr = 0; b0.rsv_en = 0; b0.rd_addr = {5'd10, 5'd9};
        settle();
        chk("indep_pend", 64'(b0.rd_pending), 64'b10);

        // mid-run reset
        b0.regWr = 1; b0.Rd = 5'd5; b0.busW = 32'h1234;
        step();
        b0.regWr = 0; b0.rsv_en = 1; b0.rsv_addr = 5'd12;
        step();
        b0.rsv_en = 0; b0.rd_addr = {5'd12, 5'd5};
        settle();
        chk("pre_rst_data", 64'(b0.rd_data), {32'h0, 32'h0, 32'h1234});
        chk("pre_rst_pend", 64'(b0.rd_pending), 64'b10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        b0.regWr = 1; b0.dst_sel = 2'd1; b0.Rd = 5'd5; b0.busW = 32'h5555;
        b0.rsv_en = 1; b0.rsv_addr = 5'd12;
        settle();
        chk("mrst_ready", 64'(b0.ready), 64'd0);
        chk("mrst_pend", 64'(b0.rd_pending), 64'd0);
        chk("mrst_data", 64'(b0.rd_data), 64'd0);
        chk("mrst_rw", 64'(b0.Rw), 64'd5);
        for (int i = 1; i <= 32; i++) begin
            step();
            chk($sformatf("mclr_ready_%0d", i), 64'(b0.ready), 64'(i == 32));
            if (i < 32) begin
                chk($sformatf("mclr_data_%0d", i), 64'(b0.rd_data), 64'd0);
                chk($sformatf("mclr_pend_%0d", i), 64'(b0.rd_pending), 64'd0);
            end
        end
        b0.regWr = 0; b0.rsv_en = 0;
        settle();
        chk("post_clr_data", 64'(b0.rd_data), 64'd0);
        chk("post_clr_pend", 64'(b0.rd_pending), 64'd0);
        b0.rd_addr = {5'd31, 5'd7};
        settle();
        chk("post_clr_old", 64'(b0.rd_data), 64'd0);

        // 16-bit, 3-port, no-bypass instance
        b1.rsv_en = 1; b1.rsv_addr = 5'd3;
        step();
        b1.rsv_en = 0;
        b1.regWr = 1; b1.dst_sel = 2'd0; b1.Rt = 5'd3; b1.busW = 16'hA5A5;
        b1.rd_addr = {5'd3, 5'd3, 5'd3};
        settle();
        chk("u1_same_data", 64'(b1.rd_data), 64'd0);
        chk("u1_same_pend", 64'(b1.rd_pending), 64'b111);
        step();
        b1.regWr = 0;
        settle();
        chk("u1_next_data", 64'(b1.rd_data), {16'h0, 16'hA5A5, 16'hA5A5, 16'hA5A5});
        chk("u1_next_pend", 64'(b1.rd_pending), 64'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
